crc_frame_source: RTL and testbench

- Upstream stage of the CRC checker. Accepts a byte stream delimited by a last flag and buffers one frame.
- Emits the frame length on the count channel, then each payload byte on the data channel, then one CRC-8 byte on the data channel, in the exact order the CRC stage consumes them.
- The CRC is computed on the fly while the frame is filling, so a correctly built frame always yields result 1 at the checker.

---
 rtl/crc_frame_source.sv | 196 +++++++++++++++++++
 tb/tb_crc_frame_source.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_source.sv
// crc_frame_source
//   Upstream stage of the CRC checker. Buffers one frame from a byte stream
//   and computes its CRC-8 while it fills. It then replays the frame to the
//   CRC stage as: the length on the count channel, each stored payload byte
//   on the data channel, and finally the CRC byte on the data channel.
//
//   CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
//
// Parameters
//   DEPTH        maximum payload bytes per frame (1..255); sizes the buffer
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     block accepts the input beat (registered)
//   in_data      payload byte
//   in_last      beat is the final beat of the frame
//   in_empty     beat carries no byte (ends a frame without adding one)
//   cnt_valid    count channel valid (registered)
//   cnt_ready    count channel ready from the CRC stage
//   cnt_data     number of stored payload bytes (registered)
//   dat_valid    data channel valid (registered)
//   dat_ready    data channel ready from the CRC stage
//   dat_data     payload byte or trailing CRC byte (registered)
//   trunc        one-cycle pulse when a frame is cut at DEPTH bytes
//   frames_sent  count of frames whose CRC byte has transferred (wraps)

module crc_frame_source #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        cnt_valid,
  input  logic        cnt_ready,
  output logic [7:0]  cnt_data,
  output logic        dat_valid,
  input  logic        dat_ready,
  output logic [7:0]  dat_data,
  output logic        trunc,
  output logic [15:0] frames_sent
);

  // Buffer address width; storage is rounded up to a power of two so the
  // address bits always cover the whole array.
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         MEM_N   = 1 << AW;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_DROP,
    ST_SEND_CNT,
    ST_SEND_DATA,
    ST_SEND_CRC
  } state_t;

  state_t      state, state_n;
  logic [7:0]  len, len_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  crc, crc_n;
  logic [15:0] frames_n;
  logic        trunc_n;
  logic        in_ready_n, cnt_valid_n, dat_valid_n;
  logic [7:0]  cnt_data_n, dat_data_n;
  logic        wr_en;
  logic        in_xfer, cnt_xfer, dat_xfer;

  logic [7:0]  mem [MEM_N];

  // Byte-wise CRC-8 step: fold the byte into the register, then shift out
  // eight bits applying the polynomial whenever the MSB falls off as 1.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state;
    len_n    = len;
    idx_n    = idx;
    crc_n    = crc;
    frames_n = frames_sent;
    trunc_n  = 1'b0;
    wr_en    = 1'b0;
    in_xfer  = in_valid  & in_ready;
    cnt_xfer = cnt_valid & cnt_ready;
    dat_xfer = dat_valid & dat_ready;

    case (state)
      ST_FILL: begin
        if (in_xfer) begin
          if (!in_empty) begin
            wr_en = 1'b1;
            crc_n = crc8_update(crc, in_data);
            len_n = len + 8'd1;
          end
          if (in_last) begin
            state_n = ST_SEND_CNT;
          end else if (!in_empty && len_n == DEPTH_L) begin
            // Buffer is full but the frame goes on: flag it and swallow the
            // rest up to in_last, keeping len and crc as they are.
            trunc_n = 1'b1;
            state_n = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (in_xfer && in_last) state_n = ST_SEND_CNT;
      end
      ST_SEND_CNT: begin
        if (cnt_xfer) begin
          idx_n   = 8'd0;
          state_n = (len == 8'd0) ? ST_SEND_CRC : ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (dat_xfer) begin
          if (idx == len - 8'd1) state_n = ST_SEND_CRC;
          else                   idx_n   = idx + 8'd1;
        end
      end
      ST_SEND_CRC: begin
        if (dat_xfer) begin
          frames_n = frames_sent + 16'd1;
          crc_n    = 8'd0;
          len_n    = 8'd0;
          state_n  = ST_FILL;
        end
      end
      default: state_n = ST_FILL;
    endcase

    // Outputs are registered copies of what the next state presents, so
    // they change on the same edge as the state itself.
    in_ready_n  = (state_n == ST_FILL) || (state_n == ST_DROP);
    cnt_valid_n = (state_n == ST_SEND_CNT);
    dat_valid_n = (state_n == ST_SEND_DATA) || (state_n == ST_SEND_CRC);

    cnt_data_n = cnt_data;
    if (state_n == ST_SEND_CNT) cnt_data_n = len_n;

    dat_data_n = dat_data;
    if (state_n == ST_SEND_DATA)     dat_data_n = mem[idx_n[AW-1:0]];
    else if (state_n == ST_SEND_CRC) dat_data_n = crc_n;
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      len         <= 8'd0;
      idx         <= 8'd0;
      crc         <= 8'd0;
      frames_sent <= 16'd0;
      trunc       <= 1'b0;
      in_ready    <= 1'b1;
      cnt_valid   <= 1'b0;
      dat_valid   <= 1'b0;
      cnt_data    <= 8'd0;
      dat_data    <= 8'd0;
    end else begin
      state       <= state_n;
      len         <= len_n;
      idx         <= idx_n;
      crc         <= crc_n;
      frames_sent <= frames_n;
      trunc       <= trunc_n;
      in_ready    <= in_ready_n;
      cnt_valid   <= cnt_valid_n;
      dat_valid   <= dat_valid_n;
      cnt_data    <= cnt_data_n;
      dat_data    <= dat_data_n;
    end
  end

  // NOTE: the payload buffer has no reset; entries are only read back after
  // being written in the current frame, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_crc_frame_source.sv
// Self-checking bench for crc_frame_source.
// A table of frame records (beats, empty mask, expected count/CRC/trunc) is
// replayed in a loop; each record pushes its expected count, data and CRC
// bytes into a scoreboard queue that a negedge monitor pops as transfers
// happen. Hand-written sequences cover random backpressure and reset
// mid-frame.

module tb_crc_frame_source;

  localparam int DEPTH = 16;
  localparam int TMO   = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_empty = 1'b0;
  logic        cnt_valid;
  logic        cnt_ready = 1'b1;
  logic [7:0]  cnt_data;
  logic        dat_valid;
  logic        dat_ready = 1'b1;
  logic [7:0]  dat_data;
  logic        trunc;
  logic [15:0] frames_sent;

  crc_frame_source #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
    .trunc(trunc), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   nbeats;
    logic [19:0]  empty_mask;
    logic [159:0] data;       // beat i at [8*i +: 8]
    logic [7:0]   exp_cnt;
    logic [7:0]   exp_crc;
    logic         exp_trunc;
  } vec_t;

  typedef enum int { RDY_ON, RDY_RAND, RDY_OFF } rdy_mode_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         trunc_seen = 0;
  logic [8:0] exp_q [$];      // {is_count, byte}
  rdy_mode_t  cnt_mode = RDY_ON;
  rdy_mode_t  dat_mode = RDY_ON;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC-8 (poly 0x07, MSB first).
  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_crc(input vec_t v);
    logic [7:0] c;
    int         stored;
    c = 8'h00;
    stored = 0;
    for (int i = 0; i < int'(v.nbeats); i++) begin
      if (!v.empty_mask[i] && stored < DEPTH) begin
        c = crc_bit(c, v.data[8*i +: 8]);
        stored++;
      end
    end
    return c;
  endfunction

  // Ready drivers: change half a cycle away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (cnt_mode)
        RDY_ON:  cnt_ready = 1'b1;
        RDY_OFF: cnt_ready = 1'b0;
        default: cnt_ready = 1'($urandom_range(0, 1));
      endcase
      case (dat_mode)
        RDY_ON:  dat_ready = 1'b1;
        RDY_OFF: dat_ready = 1'b0;
        default: dat_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sampled on the falling edge; a valid&ready seen here is the
  // transfer that completes at the following rising edge.
  logic       cnt_hold = 1'b0, dat_hold = 1'b0;
  logic [7:0] cnt_hold_data, dat_hold_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_hold = 1'b0;
      dat_hold = 1'b0;
    end else begin
      if (trunc) trunc_seen++;
      if (cnt_hold) check("cnt_stable", {cnt_valid, cnt_data}, {1'b1, cnt_hold_data});
      if (dat_hold) check("dat_stable", {dat_valid, dat_data}, {1'b1, dat_hold_data});
      if (cnt_valid || dat_valid) check("in_ready_busy", in_ready, 0);
      if (cnt_valid && cnt_ready) begin
        check("sb_has_cnt", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("cnt_xfer", {1'b1, cnt_data}, exp_q.pop_front());
      end
      if (dat_valid && dat_ready) begin
        check("sb_has_dat", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("dat_xfer", {1'b0, dat_data}, exp_q.pop_front());
      end
      cnt_hold      = cnt_valid && !cnt_ready;
      cnt_hold_data = cnt_data;
      dat_hold      = dat_valid && !dat_ready;
      dat_hold_data = dat_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic put_beat(input logic [7:0] d, input logic last, input logic empty);
    int   waited;
    logic done;
    waited = 0;
    done   = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      tick();
      if (!done) begin
        waited++;
        if (waited > TMO) begin
          check("in_ready_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic wait_frames(input logic [15:0] target);
    for (int c = 0; c < TMO; c++) begin
      if (frames_sent == target) break;
      tick();
    end
    check("frames_sent", frames_sent, target);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] old;
    int          t0, stored;
    logic        last, trunc_next;
    old = frames_sent;
    t0  = trunc_seen;
    exp_q.push_back({1'b1, v.exp_cnt});
    stored = 0;
    for (int i = 0; i < int'(v.nbeats); i++) begin
      if (!v.empty_mask[i] && stored < DEPTH) begin
        exp_q.push_back({1'b0, v.data[8*i +: 8]});
        stored++;
      end
    end
    exp_q.push_back({1'b0, v.exp_crc});

    stored = 0;
    trunc_next = 1'b0;
    for (int i = 0; i < int'(v.nbeats); i++) begin
      last = (i == int'(v.nbeats) - 1);
      put_beat(v.data[8*i +: 8], last, v.empty_mask[i]);
      if (trunc_next) begin
        check("trunc_one_cycle", trunc, 0);
        trunc_next = 1'b0;
      end
      if (!v.empty_mask[i] && stored < DEPTH) begin
        stored++;
        if (stored == DEPTH && !last) begin
          check("trunc_pulse", trunc, 1);
          trunc_next = 1'b1;
        end
      end
    end
    check("in_ready_after_last", in_ready, 0);
    check("cnt_valid_after_last", cnt_valid, 1);

    if (cnt_mode == RDY_ON && dat_mode == RDY_ON) begin
      // N+2 cycles from the in_last transfer to the CRC transfer.
      repeat (stored + 1) tick();
      check("crc_not_yet", frames_sent, old);
      tick();
      check("crc_latency", frames_sent, old + 16'd1);
      check("in_ready_reopen", in_ready, 1);
    end
    wait_frames(old + 16'd1);
    check("q_drained", exp_q.size(), 0);
    check("trunc_count", trunc_seen - t0, v.exp_trunc);
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    // ---------------- vector table ----------------
    vecs[0] = '{nbeats: 8'd9, empty_mask: '0, data: 160'h393837363534333231,
                exp_cnt: 8'd9, exp_crc: 8'hF4, exp_trunc: 1'b0};
    vecs[1] = '{nbeats: 8'd1, empty_mask: '0, data: 160'h01,
                exp_cnt: 8'd1, exp_crc: 8'h07, exp_trunc: 1'b0};
    vecs[2] = '{nbeats: 8'd2, empty_mask: '0, data: 160'h0001,
                exp_cnt: 8'd2, exp_crc: 8'h15, exp_trunc: 1'b0};
    vecs[3] = '{nbeats: 8'd1, empty_mask: 20'h00001, data: '0,
                exp_cnt: 8'd0, exp_crc: 8'h00, exp_trunc: 1'b0};
    vecs[4] = '{nbeats: 8'd20, empty_mask: '0, data: '0,
                exp_cnt: 8'd16, exp_crc: 8'h00, exp_trunc: 1'b1};
    for (int i = 0; i < 20; i++) vecs[4].data[8*i +: 8] = 8'(i + 1);
    vecs[4].exp_crc = model_crc(vecs[4]);
    vecs[5] = '{nbeats: 8'd3, empty_mask: 20'h00002, data: 160'hBB55AA,
                exp_cnt: 8'd2, exp_crc: 8'h00, exp_trunc: 1'b0};
    vecs[5].exp_crc = model_crc(vecs[5]);
    vecs[6] = '{nbeats: 8'd4, empty_mask: 20'h00008, data: 160'h00333231,
                exp_cnt: 8'd3, exp_crc: 8'h00, exp_trunc: 1'b0};
    vecs[6].exp_crc = model_crc(vecs[6]);
    vecs[7] = '{nbeats: 8'd16, empty_mask: '0, data: '0,
                exp_cnt: 8'd16, exp_crc: 8'h00, exp_trunc: 1'b0};
    for (int i = 0; i < 16; i++) vecs[7].data[8*i +: 8] = 8'(8'hF0 + i);
    vecs[7].exp_crc = model_crc(vecs[7]);

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_dat_valid", dat_valid, 0);
    check("rst_cnt_data", cnt_data, 0);
    check("rst_dat_data", dat_data, 0);
    check("rst_trunc", trunc, 0);
    check("rst_frames", frames_sent, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // ---------------- random backpressure ----------------
    cnt_mode = RDY_RAND;
    dat_mode = RDY_RAND;
    for (int f = 0; f < 4; f++) begin
      rv = '0;
      rv.nbeats = 8'($urandom_range(1, DEPTH));
      for (int i = 0; i < int'(rv.nbeats); i++) rv.data[8*i +: 8] = 8'($urandom);
      rv.exp_cnt = rv.nbeats;
      rv.exp_crc = model_crc(rv);
      run_vec(rv);
    end

    // ---------------- reset during SEND_DATA ----------------
    cnt_mode = RDY_ON;
    dat_mode = RDY_OFF;
    tick();
    exp_q.push_back({1'b1, 8'd10});
    for (int i = 0; i < 10; i++) put_beat(8'(8'h40 + i), (i == 9), 1'b0);
    for (int c = 0; c < TMO; c++) begin
      if (dat_valid) break;
      tick();
    end
    check("reached_send_data", dat_valid, 1);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cnt_valid", cnt_valid, 0);
    check("mid_rst_dat_valid", dat_valid, 0);
    check("mid_rst_cnt_data", cnt_data, 0);
    check("mid_rst_dat_data", dat_data, 0);
    check("mid_rst_trunc", trunc, 0);
    check("mid_rst_frames", frames_sent, 0);
    dat_mode = RDY_ON;
    repeat (2) tick();
    check("held_rst_dat_valid", dat_valid, 0);
    rst_n = 1'b1;
    tick();
    rv = '{nbeats: 8'd1, empty_mask: '0, data: '0,
           exp_cnt: 8'd1, exp_crc: 8'h00, exp_trunc: 1'b0};
    run_vec(rv);
    check("frames_after_reset", frames_sent, 16'd1);

    check("trunc_total", trunc_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
